tone_beeper: RTL and testbench
==============================

# tone_beeper

Parametrised programmable beeper for the piezo/speaker output. It generates a square-wave tone with a runtime-selectable half-period. The tone is gated into a beep pattern of programmable on-time, off-time and repeat count, or runs continuously until stopped. It sits between the board control logic (which issues start/stop and configuration) and the oSOUND pin.

## Interface
- DIV_W, 18: width of tone half-period setting (cycles).
- DUR_W, 24: width of on/off duration settings (cycles).
- CNT_W, 8: width of beep repeat count.

- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  synchronous, active-high reset.
- iSTART  in  1  one-cycle start request; sampled only in IDLE.
- iSTOP  in  1  abort request; honoured in any state.
- iHALF  in  DIV_W  tone half-period in cycles; latched at start.
- iON  in  DUR_W  beep on-time in cycles; latched at start.
- iOFF  in  DUR_W  gap off-time in cycles; latched at start.
- iCOUNT  in  CNT_W  number of beeps; 0 = continuous until iSTOP; latched at start.
- oSOUND  out  1  tone output.
- oBUSY  out  1  high while not IDLE.
- oDONE  out  1  one-cycle pulse when a sequence ends (normal or stopped).

## Operation
- One clock, iCLK. Reset is synchronous and active-high on iRST.
- Reset values: state=IDLE, oSOUND=0, oBUSY=0, oDONE=0. All counters are 0 and the tone phase is 0.
- FSM states: IDLE, ON, OFF.
  - IDLE -> ON: on iSTART=1 with iSTOP=0. iHALF, iON, iOFF and iCOUNT are latched in the same edge.
  - ON -> OFF: after exactly N_on cycles in ON, when beeps remain or in continuous mode.
  - ON -> IDLE: after exactly N_on cycles, when the completed beep was the iCOUNT-th. There is no trailing OFF.
  - OFF -> ON: after exactly N_off cycles.
  - Any state -> IDLE: on iSTOP=1.
- Zero settings: a latched value of 0 for iHALF, iON or iOFF is treated as 1.
- Tone divider:
  - Counts cycles only in ON.
  - Toggles the tone phase when the count reaches H-1, then wraps to 0.
  - Phase and divider clear to 0 on every entry to ON, so each beep starts low.
- oSOUND = tone phase AND (state==ON). It is driven from registers only and is 0 in IDLE and OFF.
- Beep counter:
  - Counts completed ON phases.
  - In continuous mode it does not saturate or wrap into termination, and only iSTOP ends the sequence.
- oDONE is high for one cycle, on the first IDLE cycle after leaving ON, OFF or a stop. It is not asserted after reset.
- Simultaneous events:
  - iSTOP has priority over iSTART and over any phase transition.
  - iSTART while busy is ignored; new settings are not latched.
  - iSTART and iSTOP together in IDLE: stays IDLE, no oDONE.
  - Input changes while busy have no effect until the next start.
- iRST mid-sequence: immediate return to reset values on the next edge, with no oDONE.

## Timing
- Start latency: iSTART sampled at edge k puts state=ON and oBUSY=1 from cycle k+1. oSOUND stays 0 for the first H cycles.
- oSOUND waveform inside ON: H cycles low, H cycles high, and repeating. The period is 2H cycles.
- Busy length for finite count C: C·N_on + (C−1)·N_off cycles. oDONE follows in the next cycle.
- Stop latency: iSTOP at edge k gives oSOUND=0, oBUSY=0 and oDONE=1 in cycle k+1.
- Tone in a beep is truncated at the ON boundary; there is no completion of a partial period.

## Structure
- Package beeper_pkg holds:
  - the state enum (IDLE/ON/OFF);
  - default widths DIV_W/DUR_W/CNT_W;
  - the helper constant for the zero-means-one clamp.
- Sub-module tone_div (parameter DIV_W), with ports:
  - inputs iCLK, iRST, iCLR, iEN, iHALF;
  - output oTONE.
  It is instantiated once. The FSM, the duration counter and the beep counter live in tone_beeper.

## Test plan
- Reset, then idle for 50 cycles: oSOUND=0, oBUSY=0 and oDONE=0 throughout.
- H=2, ON=8, OFF=4, COUNT=2, start:
  - each beep's oSOUND is 0,0,1,1,0,0,1,1;
  - OFF gap is 4 zeros;
  - oBUSY is high for 20 cycles;
  - oDONE pulses once in cycle 21.
- COUNT=0, H=3, ON=6, OFF=6: the pattern repeats for more than 5 beeps. iSTOP mid-ON gives oSOUND=0, oBUSY=0 and a single oDONE the next cycle.
- Zero settings H=0, ON=0, OFF=0, COUNT=3: behaves as H=1/ON=1/OFF=1. oBUSY lasts 5 cycles and oSOUND is 0 in every ON cycle.
- Change iHALF/iON and pulse iSTART during a running sequence: no effect on the waveform or length. iSTART together with iSTOP in IDLE gives no start and no oDONE.
- iRST asserted in the 3rd cycle of OFF: all outputs return to 0 next cycle, no oDONE. A subsequent start behaves identically to a fresh one.

Source files
------------

// File: rtl/beeper_pkg.sv
// rtl/beeper_pkg.sv - shared types and defaults for the tone beeper
package beeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } beepState_t;

    localparam int unsigned DEF_DIV_W = 18;
    localparam int unsigned DEF_DUR_W = 24;
    localparam int unsigned DEF_CNT_W = 8;

    // A latched setting of zero is replaced by this value
    localparam int unsigned ZERO_CLAMP = 1;

endpackage

// File: rtl/tone_div.sv
// rtl/tone_div.sv - half-period divider producing the square-wave tone phase
module tone_div
    import beeper_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iCLR,
    input  logic             iEN,
    input  logic [DIV_W-1:0] iHALF,
    output logic             oTONE
);

    logic [DIV_W-1:0] divCnt;

    always_ff @(posedge iCLK) begin
        if (iRST || iCLR) begin
            divCnt <= '0;
            oTONE  <= 1'b0;
        end else if (iEN) begin
            if (divCnt == iHALF - DIV_W'(1)) begin
                divCnt <= '0;
                oTONE  <= ~oTONE;
            end else begin
                divCnt <= divCnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_beeper.sv
// rtl/tone_beeper.sv - programmable beep sequencer gating a square-wave tone
module tone_beeper
    import beeper_pkg::*;
#(
    parameter int unsigned DIV_W = DEF_DIV_W,
    parameter int unsigned DUR_W = DEF_DUR_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic             iSTOP,
    input  logic [DIV_W-1:0] iHALF,
    input  logic [DUR_W-1:0] iON,
    input  logic [DUR_W-1:0] iOFF,
    input  logic [CNT_W-1:0] iCOUNT,
    output logic             oSOUND,
    output logic             oBUSY,
    output logic             oDONE
);

    beepState_t       state;
    logic [DIV_W-1:0] halfLat;
    logic [DUR_W-1:0] onLen;
    logic [DUR_W-1:0] offLen;
    logic [CNT_W-1:0] countLat;
    logic [DUR_W-1:0] durCnt;
    logic [CNT_W-1:0] beepCnt;
    logic             onLast;
    logic             offLast;
    logic             lastBeep;
    logic             stayOn;

    assign onLast   = (durCnt == onLen - DUR_W'(1));
    assign offLast  = (durCnt == offLen - DUR_W'(1));
    assign lastBeep = (countLat != '0) && (beepCnt == countLat - CNT_W'(1));
    // The divider is held clear whenever the next cycle is not a continuing ON cycle,
    // so its phase register is low outside ON and at the start of every beep.
    assign stayOn   = (state == ON) && !iSTOP && !onLast;

    tone_div #(
        .DIV_W(DIV_W)
    ) uToneDiv (
        .iCLK (iCLK),
        .iRST (iRST),
        .iCLR (!stayOn),
        .iEN  (state == ON),
        .iHALF(halfLat),
        .oTONE(oSOUND)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            oBUSY    <= 1'b0;
            oDONE    <= 1'b0;
            halfLat  <= '0;
            onLen    <= '0;
            offLen   <= '0;
            countLat <= '0;
            durCnt   <= '0;
            beepCnt  <= '0;
        end else begin
            oDONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (iSTART && !iSTOP) begin
                        state    <= ON;
                        oBUSY    <= 1'b1;
                        halfLat  <= (iHALF == '0) ? DIV_W'(ZERO_CLAMP) : iHALF;
                        onLen    <= (iON == '0) ? DUR_W'(ZERO_CLAMP) : iON;
                        offLen   <= (iOFF == '0) ? DUR_W'(ZERO_CLAMP) : iOFF;
                        countLat <= iCOUNT;
                        durCnt   <= '0;
                        beepCnt  <= '0;
                    end
                end
                ON: begin
                    if (iSTOP) begin
                        state  <= IDLE;
                        oBUSY  <= 1'b0;
                        oDONE  <= 1'b1;
                        durCnt <= '0;
                    end else if (onLast) begin
                        durCnt  <= '0;
                        beepCnt <= beepCnt + CNT_W'(1);
                        if (lastBeep) begin
                            state <= IDLE;
                            oBUSY <= 1'b0;
                            oDONE <= 1'b1;
                        end else begin
                            state <= OFF;
                        end
                    end else begin
                        durCnt <= durCnt + DUR_W'(1);
                    end
                end
                OFF: begin
                    if (iSTOP) begin
                        state  <= IDLE;
                        oBUSY  <= 1'b0;
                        oDONE  <= 1'b1;
                        durCnt <= '0;
                    end else if (offLast) begin
                        state  <= ON;
                        durCnt <= '0;
                    end else begin
                        durCnt <= durCnt + DUR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    oBUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_beeper.sv
// tb/tb_tone_beeper.sv - self-checking bench for tone_beeper
module tb_tone_beeper;

    typedef struct {
        int h;
        int on;
        int off;
        int cnt;
        int abortAt;
        bit abortRst;
        int perturbAt;
        int expBusy;
    } vec_t;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iSTART;
    logic        iSTOP;
    logic [17:0] iHALF;
    logic [23:0] iON;
    logic [23:0] iOFF;
    logic [7:0]  iCOUNT;
    logic        oSOUND;
    logic        oBUSY;
    logic        oDONE;

    int errors = 0;
    int checks = 0;

    always #5 iCLK = ~iCLK;

    tone_beeper #(
        .DIV_W(18),
        .DUR_W(24),
        .CNT_W(8)
    ) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iSTART(iSTART),
        .iSTOP (iSTOP),
        .iHALF (iHALF),
        .iON   (iON),
        .iOFF  (iOFF),
        .iCOUNT(iCOUNT),
        .oSOUND(oSOUND),
        .oBUSY (oBUSY),
        .oDONE (oDONE)
    );

    task automatic checkOut(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: sound/busy/done got %b required %b", name, act, exp);
        end
    endtask

    function automatic int clampOne(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    // Number of busy cycles after the start edge, including any abort
    function automatic int seqEnd(input vec_t v);
        int on  = clampOne(v.on);
        int off = clampOne(v.off);
        int t   = (v.cnt == 0) ? 32'h3fff_ffff : v.cnt * on + (v.cnt - 1) * off;
        if (v.abortAt >= 0 && v.abortAt < t) return v.abortAt + 1;
        return t;
    endfunction

    // Expected {sound, busy, done} in cycle i after the start edge
    function automatic logic [2:0] model(input vec_t v, input int i);
        int hh  = clampOne(v.h);
        int on  = clampOne(v.on);
        int off = clampOne(v.off);
        int e   = seqEnd(v);
        int pos;
        logic snd;
        if (i < e) begin
            pos = i % (on + off);
            snd = (pos < on) && (((pos / hh) % 2) == 1);
            return {snd, 1'b1, 1'b0};
        end
        if (i == e && !(v.abortRst && v.abortAt == e - 1)) return 3'b001;
        return 3'b000;
    endfunction

    task automatic runSeq(input vec_t v, input string tag);
        int busyCnt = 0;
        int len = seqEnd(v) + 4;
        @(posedge iCLK); #1;
        iHALF  = 18'(v.h);
        iON    = 24'(v.on);
        iOFF   = 24'(v.off);
        iCOUNT = 8'(v.cnt);
        iSTART = 1'b1;
        iSTOP  = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(posedge iCLK); #1;
            iSTART = (i == v.perturbAt);
            if (i == v.perturbAt) begin
                iHALF  = 18'($urandom_range(1, 9));
                iON    = 24'($urandom_range(1, 20));
                iOFF   = 24'($urandom_range(1, 9));
                iCOUNT = 8'($urandom_range(0, 5));
            end
            iSTOP = (i == v.abortAt) && !v.abortRst;
            iRST  = (i == v.abortAt) && v.abortRst;
            @(negedge iCLK);
            busyCnt += int'(oBUSY);
            checkOut($sformatf("%s cyc%0d", tag, i), {oSOUND, oBUSY, oDONE}, model(v, i));
        end
        iSTART = 1'b0;
        iSTOP  = 1'b0;
        iRST   = 1'b0;
        checks++;
        if (busyCnt != v.expBusy) begin
            errors++;
            $display("FAIL %s busyLen: got %0d required %0d", tag, busyCnt, v.expBusy);
        end
    endtask

    vec_t vecs[7];
    vec_t rv;

    initial begin
        vecs[0] = '{h: 2, on: 8, off: 4, cnt: 2, abortAt: -1, abortRst: 0, perturbAt: -1, expBusy: 20};
        vecs[1] = '{h: 0, on: 0, off: 0, cnt: 3, abortAt: -1, abortRst: 0, perturbAt: -1, expBusy: 5};
        vecs[2] = '{h: 3, on: 6, off: 6, cnt: 0, abortAt: 74, abortRst: 0, perturbAt: -1, expBusy: 75};
        vecs[3] = '{h: 4, on: 10, off: 2, cnt: 3, abortAt: -1, abortRst: 0, perturbAt: 7, expBusy: 34};
        vecs[4] = '{h: 2, on: 8, off: 4, cnt: 2, abortAt: 10, abortRst: 1, perturbAt: -1, expBusy: 11};
        vecs[5] = '{h: 2, on: 8, off: 4, cnt: 2, abortAt: -1, abortRst: 0, perturbAt: -1, expBusy: 20};
        vecs[6] = '{h: 5, on: 7, off: 0, cnt: 2, abortAt: -1, abortRst: 0, perturbAt: -1, expBusy: 15};

        iRST   = 1'b1;
        iSTART = 1'b0;
        iSTOP  = 1'b0;
        iHALF  = '0;
        iON    = '0;
        iOFF   = '0;
        iCOUNT = '0;
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b0;

        for (int i = 0; i < 50; i++) begin
            @(negedge iCLK);
            checkOut($sformatf("idle%0d", i), {oSOUND, oBUSY, oDONE}, 3'b000);
        end

        // Start and stop together in IDLE: no start, no done
        @(posedge iCLK); #1;
        iHALF  = 18'd2;
        iON    = 24'd4;
        iCOUNT = 8'd1;
        iSTART = 1'b1;
        iSTOP  = 1'b1;
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        iSTOP  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            checkOut($sformatf("startstop%0d", i), {oSOUND, oBUSY, oDONE}, 3'b000);
        end

        for (int k = 0; k < 7; k++) runSeq(vecs[k], $sformatf("vec%0d", k));

        for (int k = 0; k < 10; k++) begin
            rv.h        = $urandom_range(0, 6);
            rv.on       = $urandom_range(0, 12);
            rv.off      = $urandom_range(0, 6);
            rv.cnt      = $urandom_range(0, 4);
            rv.abortRst = ($urandom_range(0, 3) == 0);
            rv.abortAt  = -1;
            if (rv.cnt == 0) rv.abortAt = $urandom_range(0, 40);
            else if ($urandom_range(0, 1) == 1) rv.abortAt = $urandom_range(0, seqEnd(rv) - 1);
            rv.perturbAt = (seqEnd(rv) >= 2) ? $urandom_range(1, seqEnd(rv) - 1) : -1;
            rv.expBusy   = seqEnd(rv);
            runSeq(rv, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
